// File: rtl/miner_work_ctrl_pkg.sv
// Shared types and constants for the miner work controller.
package miner_work_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Second-block SHA-256 padding that sits above {nonce, header tail}.
  localparam logic [383:0] DATA_PAD = {32'h00000280, 320'h0, 32'h80000000};

  // SHA-256 initial hash value, word 0 in the least significant position.
  localparam logic [255:0] SHA256_IV =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

  // Nonce field position inside the 512-bit hasher data word.
  function automatic logic [31:0] nonce_of(input logic [511:0] data);
    return data[127:96];
  endfunction

endpackage

// File: rtl/miner_work_ctrl_golden_fifo.sv
// Small FIFO holding golden nonces; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module golden_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/miner_work_ctrl.sv
// Work sequencer for a pair of SHA-256 hashers: issues a nonce range,
// tracks results HASH_LATENCY cycles later and queues golden nonces.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  S_IDLE  | no job; work_ready high
//  S_RUN   | issuing nonces, one per LOOP cycles
//  S_DRAIN | all nonces issued, waiting for the last result slot
module miner_work_ctrl
  import miner_work_ctrl_pkg::*;
#(
  parameter int LOOP_LOG2    = 0,
  parameter int HASH_LATENCY = 130,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic         abort,
  output logic [5:0]   cnt,
  output logic         feedback,
  output logic [255:0] hasher_state,
  output logic [511:0] hasher_data,
  input  logic [31:0]  hash2_msw,
  output logic         golden_valid,
  input  logic         golden_ready,
  output logic [31:0]  golden_nonce,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam int         LOOP     = 1 << LOOP_LOG2;
  localparam logic [5:0] CNT_LAST = 6'(LOOP - 1);

  state_t                  state;
  logic [31:0]             nonce_end;
  logic [31:0]             result_nonce;
  logic [HASH_LATENCY-1:0] issue_pipe;
  logic [HASH_LATENCY-1:0] last_pipe;
  logic [5:0]              cnt_next;
  logic                    issue_slot;
  logic                    last_slot;
  logic                    result_slot;
  logic                    final_result;
  logic                    push;
  logic                    push_ready;

  assign cnt_next     = (cnt == CNT_LAST) ? 6'd0 : cnt + 6'd1;
  assign issue_slot   = (state == S_RUN) && (cnt == 6'd0);
  assign last_slot    = issue_slot && (nonce_of(hasher_data) == nonce_end);
  assign result_slot  = issue_pipe[HASH_LATENCY-1];
  assign final_result = last_pipe[HASH_LATENCY-1];
  assign push         = result_slot && (hash2_msw == 32'h0);
  assign work_ready   = (state == S_IDLE);
  assign busy         = (state != S_IDLE);

  // Job FSM, round counter, nonce issue and result-slot tracking.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 6'd0;
      feedback     <= 1'b0;
      hasher_state <= '0;
      hasher_data  <= '0;
      nonce_end    <= 32'h0;
      result_nonce <= 32'h0;
      issue_pipe   <= '0;
      last_pipe    <= '0;
      done         <= 1'b0;
    end else begin
      done       <= 1'b0;
      // Each issue slot reappears as a result slot HASH_LATENCY cycles later.
      issue_pipe <= (issue_pipe << 1) | HASH_LATENCY'(issue_slot);
      last_pipe  <= (last_pipe << 1) | HASH_LATENCY'(last_slot);
      if (result_slot) result_nonce <= result_nonce + 32'd1;

      case (state)
        S_IDLE: begin
          if (work_valid) begin
            state        <= S_RUN;
            cnt          <= 6'd0;
            feedback     <= 1'b0;
            hasher_state <= work_midstate;
            hasher_data  <= {DATA_PAD, work_nonce_start, work_data};
            nonce_end    <= work_nonce_end;
            result_nonce <= work_nonce_start;
          end
        end
        S_RUN: begin
          if (abort) begin
            state      <= S_IDLE;
            cnt        <= 6'd0;
            feedback   <= 1'b0;
            issue_pipe <= '0;
            last_pipe  <= '0;
          end else if (last_slot) begin
            state    <= S_DRAIN;
            cnt      <= 6'd0;
            feedback <= 1'b0;
          end else begin
            cnt      <= cnt_next;
            feedback <= (cnt_next != 6'd0);
            // Next nonce becomes visible exactly at the next issue slot.
            if (cnt == CNT_LAST) hasher_data[127:96] <= nonce_of(hasher_data) + 32'd1;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state      <= S_IDLE;
            issue_pipe <= '0;
            last_pipe  <= '0;
          end else if (final_result) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky flag for golden nonces lost to a full FIFO.
  always_ff @(posedge hash_clk) begin
    if (reset) overflow <= 1'b0;
    else if (push && !push_ready) overflow <= 1'b1;
  end

  golden_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_golden_fifo (
    .clk      (hash_clk),
    .reset    (reset),
    .in_valid (push),
    .in_ready (push_ready),
    .in_data  (result_nonce),
    .out_valid(golden_valid),
    .out_ready(golden_ready),
    .out_data (golden_nonce)
  );

endmodule
